// File: rtl/ram_arb_pkg.sv
// Shared types and default widths for the single-port RAM arbiter.
package ram_arb_pkg;

    localparam int RAM_ADDR_W = 8;
    localparam int RAM_DATA_W = 8;

    typedef enum logic {
        ST_CLEAR,
        ST_RUN
    } state_t;

    typedef enum logic {
        REQ_A,
        REQ_B
    } req_id_t;

endpackage

// File: rtl/ram_arb_rr2.sv
// Two-way round-robin grant: a lone request wins outright, a tie goes to the
// requester that was not granted last. Grant is one-hot or zero.
module ram_arb_rr2
    import ram_arb_pkg::*;
(
    input  logic [1:0] valid,
    input  req_id_t    last_grant,
    output logic [1:0] grant
);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        grant = valid;
        if (valid == 2'b11) begin
            grant = (last_grant == REQ_A) ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/ram_sp_arbiter.sv
// Shares one single-port RAM between requesters A and B with round-robin issue
// and a 2-cycle pipelined read response. Optional power-up clear: RAM_ARB_CLEAR_EN.
module ram_sp_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W = RAM_ADDR_W,
    parameter int DATA_W = RAM_DATA_W
`ifdef RAM_ARB_CLEAR_EN
    ,
    parameter logic [DATA_W-1:0] CLEAR_VAL = '0
`endif
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              a_req_valid,
    output logic              a_req_ready,
    input  logic              a_req_we,
    input  logic [ADDR_W-1:0] a_req_addr,
    input  logic [DATA_W-1:0] a_req_wdata,
    output logic              a_rsp_valid,
    output logic [DATA_W-1:0] a_rsp_rdata,

    input  logic              b_req_valid,
    output logic              b_req_ready,
    input  logic              b_req_we,
    input  logic [ADDR_W-1:0] b_req_addr,
    input  logic [DATA_W-1:0] b_req_wdata,
    output logic              b_rsp_valid,
    output logic [DATA_W-1:0] b_rsp_rdata,

    output logic              busy,

    output logic              ram_ce,
    output logic              ram_oce,
    output logic              ram_wre,
    output logic [ADDR_W-1:0] ram_ad,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    logic [1:0] req_valid;
    logic [1:0] grant;
    req_id_t    last_grant;
    state_t     state;
    logic       run;
    logic       xfer;
    logic       sel_b;
    logic       req_we;
    logic       rsp_p1_valid;
    req_id_t    rsp_p1_id;
`ifdef RAM_ARB_CLEAR_EN
    logic [ADDR_W-1:0] clr_addr;
`endif

    // Requests are only honoured in RUN and never while reset is held.
    assign run       = !reset && (state == ST_RUN);
    assign req_valid = {b_req_valid, a_req_valid};

    ram_arb_rr2 u_rr2 (
        .valid      (req_valid),
        .last_grant (last_grant),
        .grant      (grant)
    );

    assign a_req_ready = run && grant[0];
    assign b_req_ready = run && grant[1];
    assign xfer        = a_req_ready || b_req_ready;
    assign sel_b       = grant[1];
    assign req_we      = sel_b ? b_req_we : a_req_we;
    assign ram_oce     = 1'b1;

`ifdef RAM_ARB_CLEAR_EN
    assign busy = !reset && (state == ST_CLEAR);
`else
    assign busy = 1'b0;
`endif

    // Same-cycle issue: the accepted request goes straight onto the RAM pins.
    always_comb begin
        ram_ce  = 1'b0;
        ram_wre = 1'b0;
        ram_ad  = '0;
        ram_din = '0;
        if (xfer) begin
            ram_ce  = 1'b1;
            ram_wre = req_we;
            ram_ad  = sel_b ? b_req_addr  : a_req_addr;
            ram_din = sel_b ? b_req_wdata : a_req_wdata;
        end
`ifdef RAM_ARB_CLEAR_EN
        else if (busy) begin
            ram_ce  = 1'b1;
            ram_wre = 1'b1;
            ram_ad  = clr_addr;
            ram_din = CLEAR_VAL;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: sequential state uses non-blocking assignments only.
`ifdef RAM_ARB_CLEAR_EN
            state    <= ST_CLEAR;
            clr_addr <= '0;
`else
            state    <= ST_RUN;
`endif
            last_grant   <= REQ_B;
            rsp_p1_valid <= 1'b0;
            rsp_p1_id    <= REQ_A;
            a_rsp_valid  <= 1'b0;
            b_rsp_valid  <= 1'b0;
            a_rsp_rdata  <= '0;
            b_rsp_rdata  <= '0;
        end else begin
`ifdef RAM_ARB_CLEAR_EN
            if (state == ST_CLEAR) begin
                clr_addr <= clr_addr + 1'b1;
                if (clr_addr == '1) begin
                    state <= ST_RUN;
                end
            end
`else
            state <= ST_RUN;
`endif
            if (xfer) begin
                last_grant <= sel_b ? REQ_B : REQ_A;
            end

            // Stage 1 tracks the read the RAM is answering this cycle; stage 2
            // is the registered response itself.
            rsp_p1_valid <= xfer && !req_we;
            rsp_p1_id    <= sel_b ? REQ_B : REQ_A;
            a_rsp_valid  <= rsp_p1_valid && (rsp_p1_id == REQ_A);
            b_rsp_valid  <= rsp_p1_valid && (rsp_p1_id == REQ_B);
            if (rsp_p1_valid && (rsp_p1_id == REQ_A)) begin
                a_rsp_rdata <= ram_dout;
            end
            if (rsp_p1_valid && (rsp_p1_id == REQ_B)) begin
                b_rsp_rdata <= ram_dout;
            end
        end
    end

endmodule

// File: tb/tb_ram_sp_arbiter.sv
// Self-checking bench for ram_sp_arbiter: behavioural RAM, per-cycle reference
// model of grants and a queue of expected read responses.
module tb_ram_sp_arbiter;

    localparam int AW    = 8;
    localparam int DW    = 8;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          reset;
    logic          a_req_valid, a_req_ready, a_req_we, a_rsp_valid;
    logic [AW-1:0] a_req_addr;
    logic [DW-1:0] a_req_wdata, a_rsp_rdata;
    logic          b_req_valid, b_req_ready, b_req_we, b_rsp_valid;
    logic [AW-1:0] b_req_addr;
    logic [DW-1:0] b_req_wdata, b_rsp_rdata;
    logic          busy, ram_ce, ram_oce, ram_wre;
    logic [AW-1:0] ram_ad;
    logic [DW-1:0] ram_din, ram_dout;

    always #5 clk = ~clk;

    ram_sp_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .a_req_valid (a_req_valid),
        .a_req_ready (a_req_ready),
        .a_req_we    (a_req_we),
        .a_req_addr  (a_req_addr),
        .a_req_wdata (a_req_wdata),
        .a_rsp_valid (a_rsp_valid),
        .a_rsp_rdata (a_rsp_rdata),
        .b_req_valid (b_req_valid),
        .b_req_ready (b_req_ready),
        .b_req_we    (b_req_we),
        .b_req_addr  (b_req_addr),
        .b_req_wdata (b_req_wdata),
        .b_rsp_valid (b_rsp_valid),
        .b_rsp_rdata (b_rsp_rdata),
        .busy        (busy),
        .ram_ce      (ram_ce),
        .ram_oce     (ram_oce),
        .ram_wre     (ram_wre),
        .ram_ad      (ram_ad),
        .ram_din     (ram_din),
        .ram_dout    (ram_dout)
    );

    // Behavioural single-port RAM: write-through, read data one cycle after ce.
    logic [DW-1:0] ram_mem [DEPTH];
    always @(posedge clk) begin
        if (ram_ce) begin
            if (ram_wre) begin
                ram_mem[ram_ad] <= ram_din;
                ram_dout        <= ram_din;
            end else begin
                ram_dout <= ram_mem[ram_ad];
            end
        end
    end

    // Reference model state.
    typedef struct {
        int            due;
        bit            is_b;
        logic [DW-1:0] data;
    } rsp_t;

    logic [DW-1:0] model_mem [DEPTH];
    rsp_t          rsp_q[$];
    bit            last_b;
    logic [DW-1:0] exp_rd_a, exp_rd_b;
    int            clear_left;
    int            cyc;
    bit            ga, gb;
    int            total, passed, failed;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            failed++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        rsp_q.delete();
        last_b   = 1'b1;
        exp_rd_a = '0;
        exp_rd_b = '0;
        clear_left = 0;
`ifdef RAM_ARB_CLEAR_EN
        clear_left = DEPTH;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
`endif
    endtask

    // One clock cycle: drive after the falling edge, check 1 time unit later.
    task automatic step(input bit rst,
                        input bit av, input bit awe, input logic [AW-1:0] aad, input logic [DW-1:0] awd,
                        input bit bv, input bit bwe, input logic [AW-1:0] bad, input logic [DW-1:0] bwd);
        bit            exp_av, exp_bv, we;
        logic [AW-1:0] ad;
        logic [DW-1:0] wd;
        @(negedge clk);
        cyc++;
        reset       = rst;
        a_req_valid = av;  a_req_we = awe;  a_req_addr = aad;  a_req_wdata = awd;
        b_req_valid = bv;  b_req_we = bwe;  b_req_addr = bad;  b_req_wdata = bwd;
        #1;
        exp_av = 1'b0;
        exp_bv = 1'b0;
        if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
            rsp_t r;
            r = rsp_q.pop_front();
            if (r.is_b) begin exp_bv = 1'b1; exp_rd_b = r.data; end
            else        begin exp_av = 1'b1; exp_rd_a = r.data; end
        end
        check("a_rsp_valid", a_rsp_valid, exp_av);
        check("b_rsp_valid", b_rsp_valid, exp_bv);
        check("a_rsp_rdata", a_rsp_rdata, exp_rd_a);
        check("b_rsp_rdata", b_rsp_rdata, exp_rd_b);
        ga = 1'b0;
        gb = 1'b0;
        if (rst) begin
            check("rst_a_ready", a_req_ready, 1'b0);
            check("rst_b_ready", b_req_ready, 1'b0);
            check("rst_ram_ce", ram_ce, 1'b0);
            model_reset();
            return;
        end
        if (clear_left > 0) begin
            check("clr_busy", busy, 1'b1);
            check("clr_a_ready", a_req_ready, 1'b0);
            check("clr_b_ready", b_req_ready, 1'b0);
            check("clr_ram_ce", ram_ce, 1'b1);
            check("clr_ram_wre", ram_wre, 1'b1);
            check("clr_ram_ad", ram_ad, 32'(DEPTH - clear_left));
            clear_left--;
            return;
        end
        check("busy", busy, 1'b0);
        check("ram_oce", ram_oce, 1'b1);
        // Lone requester wins; a tie goes to whoever was not granted last.
        if (av && bv) begin
            ga = last_b;
            gb = !last_b;
        end else begin
            ga = av;
            gb = bv;
        end
        check("a_req_ready", a_req_ready, ga);
        check("b_req_ready", b_req_ready, gb);
        check("ram_ce", ram_ce, ga || gb);
        if (ga || gb) begin
            we = ga ? awe : bwe;
            ad = ga ? aad : bad;
            wd = ga ? awd : bwd;
            check("ram_wre", ram_wre, we);
            check("ram_ad", ram_ad, ad);
            if (we) check("ram_din", ram_din, wd);
            last_b = gb;
            if (we) model_mem[ad] = wd;
            else    rsp_q.push_back('{due: cyc + 2, is_b: gb, data: model_mem[ad]});
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    bit            pa, pb, pa_we, pb_we;
    logic [AW-1:0] pa_ad, pb_ad;
    logic [DW-1:0] pa_wd, pb_wd;

    initial begin
        total = 0; passed = 0; failed = 0; cyc = 0;
        reset = 1'b1;
        a_req_valid = 0; a_req_we = 0; a_req_addr = '0; a_req_wdata = '0;
        b_req_valid = 0; b_req_we = 0; b_req_addr = '0; b_req_wdata = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ram_mem[i]   = 8'($urandom);
            model_mem[i] = ram_mem[i];
        end
        model_reset();
        repeat (2) @(posedge clk);

        // Modelled reset, then reset-state checks on the first cycle out of it.
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 8'h11, 0, 1, 0, 8'h22, 0);

        // Power-up clear: ready held low throughout, then a read returns the clear value.
        while (clear_left > 0) step(0, 1, 0, 8'(cyc), 0, 1, 1, 8'(cyc), 8'hEE);
        step(0, 1, 0, 8'hFF, 0, 0, 0, 0, 0);
        idle(2);
`ifdef RAM_ARB_CLEAR_EN
        check("clear_read_ff", a_rsp_rdata, 8'h00);
`endif

        // Single read after write.
        step(0, 1, 1, 8'h10, 8'h5A, 0, 0, 0, 0);
        step(0, 1, 0, 8'h10, 0, 0, 0, 0, 0);
        idle(2);
        check("t1_a_rsp_valid", a_rsp_valid, 1'b1);
        check("t1_a_rsp_rdata", a_rsp_rdata, 8'h5A);
        idle(1);

        // Write then read of the same address on the next cycle, other requester.
        step(0, 1, 1, 8'h20, 8'hC3, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0, 8'h20, 0);
        idle(2);
        check("t6_b_rsp_rdata", b_rsp_rdata, 8'hC3);
        idle(1);

        // Contention: both hold reads for four cycles.
        for (int i = 0; i < 4; i++) step(0, 1, 0, 8'h01, 0, 1, 0, 8'h02, 0);
        idle(3);

        // Back-to-back stream from A.
        for (int i = 0; i < 16; i++) step(0, 1, 0, 8'(i), 0, 0, 0, 0, 0);
        idle(3);

        // Reset one cycle after a read transfer.
        step(0, 1, 0, 8'h30, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(1);
`ifndef RAM_ARB_CLEAR_EN
        check("t4_ram_wre", ram_wre, 1'b0);
        check("t4_ram_ad", ram_ad, 8'h00);
        check("t4_ram_din", ram_din, 8'h00);
`endif
        idle(2);

        // Randomized traffic with valid held until accepted; one reset mid-run.
        pa = 0; pb = 0;
        pa_we = 0; pb_we = 0; pa_ad = '0; pb_ad = '0; pa_wd = '0; pb_wd = '0;
        for (int i = 0; i < 800; i++) begin
            if (!pa && $urandom_range(0, 9) < 7) begin
                pa = 1; pa_we = 1'($urandom_range(0, 1));
                pa_ad = 8'($urandom_range(0, 15)); pa_wd = 8'($urandom);
            end
            if (!pb && $urandom_range(0, 9) < 7) begin
                pb = 1; pb_we = 1'($urandom_range(0, 1));
                pb_ad = 8'($urandom_range(0, 15)); pb_wd = 8'($urandom);
            end
            step(i == 400, pa, pa_we, pa_ad, pa_wd, pb, pb_we, pb_ad, pb_wd);
            if (ga) pa = 0;
            if (gb) pb = 0;
        end
        idle(4);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
